// File: rtl/cache_bus_arbiter.sv
// Shares one AHB cache-line bus engine between the I$ and D$ miss FSMs; D$ has starvation-bounded priority.
// Optional HPM event counters are built when CACHEARB_PERF_EN is defined.
module cache_bus_arbiter #(
    parameter int PA_BITS    = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         IBusRW,
    input  logic [PA_BITS-1:0] IBusAdr,
    input  logic               IFlushStage,
    output logic               IBusAck,
    input  logic [1:0]         DBusRW,
    input  logic [PA_BITS-1:0] DBusAdr,
    input  logic               DFlushStage,
    output logic               DBusAck,
    output logic [1:0]         BusRW,
    output logic [PA_BITS-1:0] BusAdr,
    input  logic               BusAck,
    output logic               GrantD
`ifdef CACHEARB_PERF_EN
    ,
    output logic [31:0]        ContendCnt,
    output logic [31:0]        IStallCnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_I  = 2'd1,
        GNT_D  = 2'd2,
        HOLD_D = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       i_pend;
    logic       d_pend;
    logic       d_win;

    // Flush masks only a request that has not yet been granted.
    assign i_pend  = IBusRW[1] & ~IFlushStage;
    assign d_pend  = (DBusRW != 2'b00) & ~DFlushStage;
    assign d_win   = d_pend & (~i_pend | (starve_cnt < STARVE_LIM));
    assign IBusAck = BusAck & (state == GNT_I);
    assign DBusAck = BusAck & (state == GNT_D);

    // Grant FSM; bus request and owner flag are registered at grant and held until BusAck.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            BusRW  <= 2'b00;
            BusAdr <= '0;
            GrantD <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_win) begin
                        state  <= GNT_D;
                        BusRW  <= DBusRW;
                        BusAdr <= DBusAdr;
                        GrantD <= 1'b1;
                    end else if (i_pend) begin
                        state  <= GNT_I;
                        BusRW  <= IBusRW;
                        BusAdr <= IBusAdr;
                        GrantD <= 1'b0;
                    end
                end
                GNT_I: begin
                    if (BusAck) begin
                        state <= IDLE;
                        BusRW <= 2'b00;
                    end
                end
                GNT_D: begin
                    if (BusAck) begin
                        state  <= (BusRW == 2'b01) ? HOLD_D : IDLE;
                        BusRW  <= 2'b00;
                        GrantD <= 1'b0;
                    end
                end
                HOLD_D: begin
                    if (DBusRW == 2'b10) begin
                        state  <= GNT_D;
                        BusRW  <= DBusRW;
                        BusAdr <= DBusAdr;
                        GrantD <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    BusRW  <= 2'b00;
                    GrantD <= 1'b0;
                end
            endcase
        end
    end

    // Counts D$ wins from IDLE while the I$ keeps asking; saturates at the limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (!IBusRW[1]) begin
            starve_cnt <= 4'd0;
        end else if (state == IDLE) begin
            if (d_win) begin
                if (starve_cnt < STARVE_LIM) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end else if (i_pend) begin
                starve_cnt <= 4'd0;
            end
        end
    end

`ifdef CACHEARB_PERF_EN
    // Free-running event counters for the HPM; wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ContendCnt <= 32'd0;
            IStallCnt  <= 32'd0;
        end else begin
            if ((state == IDLE) && i_pend && d_pend) begin
                ContendCnt <= ContendCnt + 32'd1;
            end
            if (IBusRW[1] && (state != GNT_I)) begin
                IStallCnt <= IStallCnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench for cache_bus_arbiter: directed scenarios plus randomized traffic against an owner-level model.
module tb_cache_bus_arbiter;
    localparam int PA = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    IBusRW, DBusRW, BusRW;
    logic [PA-1:0] IBusAdr, DBusAdr, BusAdr;
    logic          IFlushStage, DFlushStage, IBusAck, DBusAck, BusAck, GrantD;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who owns the bus, whether a writeback reserved the next cycle, and the D$ win streak.
    int            m_owner = 0;   // 0 none, 1 I$, 2 D$
    logic          m_hold = 1'b0;
    logic [1:0]    m_rw = 2'b00;
    logic [PA-1:0] m_adr = '0;
    int            m_streak = 0;
    logic          m_ip, m_dp, m_dwin;

    cache_bus_arbiter #(.PA_BITS(PA), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .IBusRW(IBusRW), .IBusAdr(IBusAdr), .IFlushStage(IFlushStage), .IBusAck(IBusAck),
        .DBusRW(DBusRW), .DBusAdr(DBusAdr), .DFlushStage(DFlushStage), .DBusAck(DBusAck),
        .BusRW(BusRW), .BusAdr(BusAdr), .BusAck(BusAck), .GrantD(GrantD)
    );

    always #5 clk = ~clk;

    assign m_ip   = IBusRW[1] && !IFlushStage;
    assign m_dp   = (DBusRW != 2'b00) && !DFlushStage;
    assign m_dwin = m_dp && (!m_ip || (m_streak < SM));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owner <= 0; m_hold <= 1'b0; m_rw <= 2'b00; m_adr <= '0; m_streak <= 0;
        end else begin
            if (m_hold) begin
                m_hold <= 1'b0;
                if (DBusRW == 2'b10) begin
                    m_owner <= 2; m_rw <= DBusRW; m_adr <= DBusAdr;
                end
            end else if (m_owner == 0) begin
                if (m_dwin) begin
                    m_owner <= 2; m_rw <= DBusRW; m_adr <= DBusAdr;
                end else if (m_ip) begin
                    m_owner <= 1; m_rw <= IBusRW; m_adr <= IBusAdr;
                end
            end else if (BusAck) begin
                m_owner <= 0; m_rw <= 2'b00;
                m_hold <= (m_owner == 2) && (m_rw == 2'b01);
            end
            if (!IBusRW[1]) m_streak <= 0;
            else if (m_owner == 0 && !m_hold) begin
                if (m_dwin) m_streak <= (m_streak < SM) ? m_streak + 1 : SM;
                else if (m_ip) m_streak <= 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IBusRW = 2'b00; IBusAdr = '0; IFlushStage = 1'b0;
        DBusRW = 2'b00; DBusAdr = '0; DFlushStage = 1'b0;
        BusAck = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        BusAck = 1'b1;
        #1;
        vectors++; if (IBusAck !== 1'b0) begin miscompares++; $display("FAIL reset_iack: got %b want 0", IBusAck); end
        vectors++; if (DBusAck !== 1'b0) begin miscompares++; $display("FAIL reset_dack: got %b want 0", DBusAck); end
        tick(); tick();
        BusAck = 1'b0;
        vectors++; if (BusRW !== 2'b00) begin miscompares++; $display("FAIL reset_busrw: got %b want 00", BusRW); end
        vectors++; if (BusAdr !== 32'h0) begin miscompares++; $display("FAIL reset_busadr: got %h want 0", BusAdr); end
        vectors++; if (GrantD !== 1'b0) begin miscompares++; $display("FAIL reset_grantd: got %b want 0", GrantD); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_ifetch();
        idle_inputs();
        IBusRW = 2'b10; IBusAdr = 32'h8000_0040;
        tick();
        vectors++; if ({BusRW, GrantD} !== {2'b10, 1'b0}) begin miscompares++; $display("FAIL ifetch_grant: got rw=%b gd=%b want rw=10 gd=0", BusRW, GrantD); end
        vectors++; if (BusAdr !== 32'h8000_0040) begin miscompares++; $display("FAIL ifetch_adr: got %h want 80000040", BusAdr); end
        tick(); tick();
        vectors++; if (BusRW !== 2'b10) begin miscompares++; $display("FAIL ifetch_stable: got %b want 10", BusRW); end
        BusAck = 1'b1;
        #1;
        vectors++; if ({IBusAck, DBusAck} !== 2'b10) begin miscompares++; $display("FAIL ifetch_ack: got i=%b d=%b want i=1 d=0", IBusAck, DBusAck); end
        tick();
        BusAck = 1'b0; IBusRW = 2'b00;
        #1;
        vectors++; if ({BusRW, IBusAck} !== 3'b000) begin miscompares++; $display("FAIL ifetch_idle: got rw=%b iack=%b want 00/0", BusRW, IBusAck); end
        tick();
    endtask

    task automatic test_contention();
        idle_inputs();
        IBusRW = 2'b10; IBusAdr = 32'h0000_1000;
        DBusRW = 2'b10; DBusAdr = 32'h0000_2000;
        tick();
        vectors++; if ({GrantD, BusRW, BusAdr} !== {1'b1, 2'b10, 32'h0000_2000}) begin miscompares++; $display("FAIL contend_dwin: got gd=%b rw=%b adr=%h want 1/10/00002000", GrantD, BusRW, BusAdr); end
        BusAck = 1'b1;
        #1;
        vectors++; if ({IBusAck, DBusAck} !== 2'b01) begin miscompares++; $display("FAIL contend_dack: got i=%b d=%b want 0/1", IBusAck, DBusAck); end
        tick();
        BusAck = 1'b0; DBusRW = 2'b00;
        #1;
        vectors++; if ({GrantD, BusRW} !== 3'b000) begin miscompares++; $display("FAIL contend_turn: got gd=%b rw=%b want 0/00", GrantD, BusRW); end
        tick();
        vectors++; if ({GrantD, BusRW, BusAdr} !== {1'b0, 2'b10, 32'h0000_1000}) begin miscompares++; $display("FAIL contend_iwin: got gd=%b rw=%b adr=%h want 0/10/00001000", GrantD, BusRW, BusAdr); end
        BusAck = 1'b1;
        #1;
        vectors++; if (IBusAck !== 1'b1) begin miscompares++; $display("FAIL contend_iack: got %b want 1", IBusAck); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_writeback_hold();
        idle_inputs();
        IBusRW = 2'b10; IBusAdr = 32'h0000_3000;
        DBusRW = 2'b01; DBusAdr = 32'h0000_0100;
        tick();
        vectors++; if ({GrantD, BusRW, BusAdr} !== {1'b1, 2'b01, 32'h0000_0100}) begin miscompares++; $display("FAIL wb_grant: got gd=%b rw=%b adr=%h want 1/01/00000100", GrantD, BusRW, BusAdr); end
        BusAck = 1'b1;
        #1;
        vectors++; if (DBusAck !== 1'b1) begin miscompares++; $display("FAIL wb_ack: got %b want 1", DBusAck); end
        tick();
        BusAck = 1'b0; DBusRW = 2'b10; DBusAdr = 32'h0000_0200;
        #1;
        vectors++; if ({BusRW, IBusAck} !== 3'b000) begin miscompares++; $display("FAIL wb_hold: got rw=%b iack=%b want 00/0", BusRW, IBusAck); end
        tick();
        vectors++; if ({GrantD, BusRW, BusAdr} !== {1'b1, 2'b10, 32'h0000_0200}) begin miscompares++; $display("FAIL wb_refill: got gd=%b rw=%b adr=%h want 1/10/00000200", GrantD, BusRW, BusAdr); end
        BusAck = 1'b1;
        #1;
        vectors++; if ({IBusAck, DBusAck} !== 2'b01) begin miscompares++; $display("FAIL wb_refill_ack: got i=%b d=%b want 0/1", IBusAck, DBusAck); end
        tick();
        BusAck = 1'b0; DBusRW = 2'b00;
        tick();
        vectors++; if ({GrantD, BusRW, BusAdr} !== {1'b0, 2'b10, 32'h0000_3000}) begin miscompares++; $display("FAIL wb_ithen: got gd=%b rw=%b adr=%h want 0/10/00003000", GrantD, BusRW, BusAdr); end
        BusAck = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        logic exp_d;
        idle_inputs();
        IBusRW = 2'b10; IBusAdr = 32'h0000_4000;
        DBusRW = 2'b10; DBusAdr = 32'h0000_5000;
        for (int g = 0; g < 6; g++) begin
            exp_d = (g != 4);
            tick();
            vectors++; if ({GrantD, BusAdr} !== {exp_d, exp_d ? 32'h0000_5000 : 32'h0000_4000}) begin miscompares++; $display("FAIL starve_grant%0d: got gd=%b adr=%h want gd=%b", g, GrantD, BusAdr, exp_d); end
            BusAck = 1'b1;
            #1;
            vectors++; if ({IBusAck, DBusAck} !== {!exp_d, exp_d}) begin miscompares++; $display("FAIL starve_ack%0d: got i=%b d=%b want d=%b", g, IBusAck, DBusAck, exp_d); end
            tick();
            BusAck = 1'b0;
            #1;
            vectors++; if (BusRW !== 2'b00) begin miscompares++; $display("FAIL starve_idle%0d: got %b want 00", g, BusRW); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_flush();
        idle_inputs();
        DBusRW = 2'b10; DBusAdr = 32'h0000_6000; DFlushStage = 1'b1;
        tick(); tick();
        vectors++; if ({GrantD, BusRW} !== 3'b000) begin miscompares++; $display("FAIL dflush_mask: got gd=%b rw=%b want 0/00", GrantD, BusRW); end
        DFlushStage = 1'b0;
        tick();
        vectors++; if ({GrantD, BusRW} !== 3'b110) begin miscompares++; $display("FAIL dflush_grant: got gd=%b rw=%b want 1/10", GrantD, BusRW); end
        DFlushStage = 1'b1;
        tick();
        vectors++; if ({GrantD, BusRW} !== 3'b110) begin miscompares++; $display("FAIL dflush_commit: got gd=%b rw=%b want 1/10", GrantD, BusRW); end
        BusAck = 1'b1;
        #1;
        vectors++; if (DBusAck !== 1'b1) begin miscompares++; $display("FAIL dflush_ack: got %b want 1", DBusAck); end
        tick();
        idle_inputs();
        IBusRW = 2'b10; IBusAdr = 32'h0000_7000; IFlushStage = 1'b1;
        tick();
        vectors++; if (BusRW !== 2'b00) begin miscompares++; $display("FAIL iflush_mask: got %b want 00", BusRW); end
        IFlushStage = 1'b0;
        tick();
        vectors++; if ({GrantD, BusRW, BusAdr} !== {1'b0, 2'b10, 32'h0000_7000}) begin miscompares++; $display("FAIL iflush_grant: got gd=%b rw=%b adr=%h", GrantD, BusRW, BusAdr); end
        BusAck = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        idle_inputs();
        IBusRW = 2'b10; IBusAdr = 32'h0000_8000;
        tick();
        vectors++; if (BusRW !== 2'b10) begin miscompares++; $display("FAIL rstmid_pre: got %b want 10", BusRW); end
        BusAck = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        vectors++; if ({BusRW, IBusAck, GrantD} !== 4'b0000) begin miscompares++; $display("FAIL rstmid_async: got rw=%b iack=%b gd=%b want 00/0/0", BusRW, IBusAck, GrantD); end
        BusAck = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        vectors++; if ({BusRW, BusAdr} !== {2'b10, 32'h0000_8000}) begin miscompares++; $display("FAIL rstmid_regrant: got rw=%b adr=%h want 10/00008000", BusRW, BusAdr); end
        BusAck = 1'b1;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        logic i_done, d_done, d_wb, exp_i, exp_d;
        i_done = 1'b0; d_done = 1'b0; d_wb = 1'b0;
        idle_inputs();
        tick();
        for (int c = 0; c < 800; c++) begin
            if (i_done) IBusRW = 2'b00;
            if (d_done) begin
                if (d_wb && ($urandom_range(0, 1) == 1)) begin
                    DBusRW = 2'b10; DBusAdr = $urandom() & 32'hFFFF_FFC0;
                end else begin
                    DBusRW = 2'b00;
                end
            end
            if (IBusRW == 2'b00 && $urandom_range(0, 3) == 0) begin
                IBusRW = 2'b10; IBusAdr = $urandom() & 32'hFFFF_FFC0;
            end
            if (DBusRW == 2'b00 && $urandom_range(0, 3) == 0) begin
                DBusRW = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
                DBusAdr = $urandom() & 32'hFFFF_FFC0;
            end
            IFlushStage = ($urandom_range(0, 7) == 0);
            DFlushStage = ($urandom_range(0, 7) == 0);
            BusAck = (m_owner != 0) && !m_hold && ($urandom_range(0, 2) == 0);
            exp_i = BusAck && (m_owner == 1);
            exp_d = BusAck && (m_owner == 2);
            #1;
            vectors++;
            if ({BusRW, GrantD, IBusAck, DBusAck} !== {m_rw, (m_owner == 2), exp_i, exp_d}) begin
                miscompares++;
                $display("FAIL rand_c%0d: got rw=%b gd=%b ia=%b da=%b want rw=%b gd=%b ia=%b da=%b",
                         c, BusRW, GrantD, IBusAck, DBusAck, m_rw, (m_owner == 2), exp_i, exp_d);
            end
            if (m_owner != 0) begin
                vectors++;
                if (BusAdr !== m_adr) begin
                    miscompares++;
                    $display("FAIL rand_adr_c%0d: got %h want %h", c, BusAdr, m_adr);
                end
            end
            i_done = exp_i;
            d_done = exp_d;
            d_wb   = (m_rw == 2'b01);
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ifetch();
        test_contention();
        test_writeback_hold();
        test_starvation();
        test_flush();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
